// File: rtl/uart_rx_frame_controller.sv
// 8N1 UART receive sequencer with a one-deep valid/ready holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data bit 7 and the stop bit.
module uart_rx_frame_controller #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clockIN,
  input  logic       nResetIN,
  input  logic       rxIN,
  input  logic       readyIN,
  output logic [7:0] dataOUT,
  output logic       validOUT,
  output logic       frameErrorOUT,
  output logic       overrunOUT,
  output logic       busyOUT
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        byte_done;
`ifdef UART_RX_PARITY_EN
  logic        par_err_q, par_err_d;
`endif

  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxIN) state_d = S_START;
      end
      S_START: begin
        // Re-check the line mid start bit so a short glitch is a false start
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rxIN) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rxIN;
          bit_idx_d        = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_err_d = ^{shift_q, rxIN};
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (!rxIN) begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
`endif
          end else begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        // A held-low line must return high before another start can be seen
        cnt_d = '0;
        if (rxIN) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Holding register: a same-cycle consume makes room for the new byte
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && readyIN) valid_d = 1'b0;
    if (byte_done) begin
      if (!valid_q || readyIN) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign dataOUT       = data_q;
  assign validOUT      = valid_q;
  assign frameErrorOUT = frame_err_q;
  assign overrunOUT    = overrun_q;
  assign busyOUT       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_controller.sv
// Directed bench for uart_rx_frame_controller at 8 clocks per bit.
module tb_uart_rx_frame_controller;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int VLD_DELAY = FRAME_BITS * CPB - 3;

  logic       clk = 1'b0;
  logic       nResetIN;
  logic       rxIN;
  logic       readyIN;
  logic [7:0] dataOUT;
  logic       validOUT;
  logic       frameErrorOUT;
  logic       overrunOUT;
  logic       busyOUT;

  int tests = 0;
  int fails = 0;

  int         cyc_n = 0;
  int         vld_cnt = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         last_vld_cyc = 0;
  logic [7:0] last_vld_data = 8'h00;

`ifdef UART_RX_PARITY_EN
  logic par_bad = 1'b0;
`endif

  uart_rx_frame_controller #(.CLKS_PER_BIT(CPB)) dut (
    .clockIN(clk),
    .nResetIN(nResetIN),
    .rxIN(rxIN),
    .readyIN(readyIN),
    .dataOUT(dataOUT),
    .validOUT(validOUT),
    .frameErrorOUT(frameErrorOUT),
    .overrunOUT(overrunOUT),
    .busyOUT(busyOUT)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (validOUT) begin
      vld_cnt       <= vld_cnt + 1;
      last_vld_cyc  <= cyc_n;
      last_vld_data <= dataOUT;
    end
    if (frameErrorOUT) fe_cnt <= fe_cnt + 1;
    if (overrunOUT)    ov_cnt <= ov_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxIN = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rxIN = b[i];
      repeat (CPB) tick();
    end
`ifdef UART_RX_PARITY_EN
    rxIN = (^b) ^ par_bad;
    repeat (CPB) tick();
`endif
    rxIN = stop_bit;
    repeat (CPB) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(dataOUT),       32'h00);
    check({tag, "_valid"}, 32'(validOUT),      32'h0);
    check({tag, "_fe"},    32'(frameErrorOUT), 32'h0);
    check({tag, "_ov"},    32'(overrunOUT),    32'h0);
    check({tag, "_busy"},  32'(busyOUT),       32'h0);
  endtask

  initial begin
    int base_cyc, v0, f0, o0;
    nResetIN = 1'b0;
    rxIN     = 1'b1;
    readyIN  = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (3) tick();
    check_reset_outputs("por_held");
    nResetIN = 1'b1;
    repeat (4) tick();

    // Frame 0xA5, consumer always ready
    v0 = vld_cnt; f0 = fe_cnt; o0 = ov_cnt;
    base_cyc = cyc_n;
    send_frame(8'hA5, 1'b1);
    repeat (4) tick();
    check("a5_pulses",  32'(vld_cnt - v0), 32'd1);
    check("a5_latency", 32'(last_vld_cyc - base_cyc), 32'(VLD_DELAY));
    check("a5_data",    32'(last_vld_data), 32'hA5);
    check("a5_fe",      32'(fe_cnt - f0), 32'd0);
    check("a5_ov",      32'(ov_cnt - o0), 32'd0);
    check("a5_busy",    32'(busyOUT), 32'd0);

    // Second pattern with both end bits set
    v0 = vld_cnt;
    send_frame(8'h81, 1'b1);
    repeat (4) tick();
    check("81_pulses", 32'(vld_cnt - v0), 32'd1);
    check("81_data",   32'(last_vld_data), 32'h81);

    // False start: 2-cycle low glitch
    v0 = vld_cnt; f0 = fe_cnt;
    rxIN = 1'b0;
    tick();
    tick();
    rxIN = 1'b1;
    check("fs_busy_hi", 32'(busyOUT), 32'd1);
    repeat (3) tick();
    check("fs_busy_lo", 32'(busyOUT), 32'd0);
    repeat (20) tick();
    check("fs_valid", 32'(vld_cnt - v0), 32'd0);
    check("fs_fe",    32'(fe_cnt - f0), 32'd0);

    // Bad stop bit followed by a long break
    v0 = vld_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (40) tick();
    check("brk_busy", 32'(busyOUT), 32'd1);
    check("brk_fe",   32'(fe_cnt - f0), 32'd1);
    rxIN = 1'b1;
    tick();
    check("brk_idle",  32'(busyOUT), 32'd0);
    repeat (4) tick();
    check("brk_valid", 32'(vld_cnt - v0), 32'd0);
    check("brk_fe_once", 32'(fe_cnt - f0), 32'd1);

    // Overrun: consumer stalled across two frames
    o0 = ov_cnt;
    readyIN = 1'b0;
    send_frame(8'h11, 1'b1);
    repeat (3) tick();
    send_frame(8'h22, 1'b1);
    repeat (3) tick();
    check("ovr_valid", 32'(validOUT), 32'd1);
    check("ovr_data",  32'(dataOUT), 32'h11);
    check("ovr_pulse", 32'(ov_cnt - o0), 32'd1);
    readyIN = 1'b1;
    tick();
    check("ovr_drain", 32'(validOUT), 32'd0);
    check("ovr_keep",  32'(dataOUT), 32'h11);

    // Reset in the middle of data bit 4 of 0xFF
    rxIN = 1'b0;
    repeat (CPB) tick();
    rxIN = 1'b1;
    repeat (4 * CPB + 3) tick();
    check("mid_busy", 32'(busyOUT), 32'd1);
    nResetIN = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) tick();
    nResetIN = 1'b1;
    repeat (CPB * 6) tick();
    v0 = vld_cnt;
    send_frame(8'h5A, 1'b1);
    repeat (4) tick();
    check("rst_pulses", 32'(vld_cnt - v0), 32'd1);
    check("rst_data",   32'(last_vld_data), 32'h5A);

`ifdef UART_RX_PARITY_EN
    v0 = vld_cnt; f0 = fe_cnt;
    par_bad = 1'b0;
    send_frame(8'h07, 1'b1);
    repeat (4) tick();
    check("par_ok_vld",  32'(vld_cnt - v0), 32'd1);
    check("par_ok_data", 32'(last_vld_data), 32'h07);
    check("par_ok_fe",   32'(fe_cnt - f0), 32'd0);
    v0 = vld_cnt; f0 = fe_cnt;
    par_bad = 1'b1;
    send_frame(8'h07, 1'b1);
    repeat (4) tick();
    par_bad = 1'b0;
    check("par_bad_vld",  32'(vld_cnt - v0), 32'd0);
    check("par_bad_fe",   32'(fe_cnt - f0), 32'd1);
    check("par_bad_busy", 32'(busyOUT), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_controller.md
Name: uart_rx_frame_controller

Overview:
- Sequences reception of 8N1 UART frames from an rx line that has already been synchronised and deglitched upstream.
- Times start, data and stop sampling with a bit-period counter and assembles the data byte LSB first.
- Presents each byte to the WS2811 command/pixel logic through a one-deep holding register with a valid/ready handshake.
- Reports framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 434, clockIN cycles per bit (50 MHz / 115200). Legal range 4..65535.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), start-bit confirmation delay. Derived; must not be overridden.

Ports:
- clockIN  input  1  system clock
- nResetIN  input  1  asynchronous active-low reset
- rxIN  input  1  filtered, synchronised rx line; idle high
- readyIN  input  1  consumer accepts dataOUT this cycle when validOUT=1
- dataOUT  output  8  received byte
- validOUT  output  1  holding register full
- frameErrorOUT  output  1  one-cycle pulse: stop bit (or parity) bad
- overrunOUT  output  1  one-cycle pulse: completed byte dropped because holding register full
- busyOUT  output  1  high in any state other than IDLE

Behaviour:
- Reset: clockIN and nResetIN only. nResetIN low is asynchronous and active-low. It forces state IDLE, counter 0, shift register 0, dataOUT=0x00, validOUT=0, frameErrorOUT=0, overrunOUT=0, busyOUT=0.
- Reset mid-frame: the partial byte is discarded. After release, the first low seen in IDLE starts a new frame.
- Counter: 16-bit bit-period counter. Returns to 0 on each state entry and on each sample.
- IDLE:
  - rxIN=0 -> START, counter=0.
  - rxIN=1 -> stay.
- START: when counter==HALF_BIT-1, sample rxIN.
  - 0 -> DATA, bitIndex=0.
  - 1 -> false start, back to IDLE with no flags.
- DATA: when counter==CLKS_PER_BIT-1, sample rxIN into shift[bitIndex] (LSB first), then increment bitIndex. After bitIndex 7 is sampled -> STOP (or PARITY, see Optional Feature).
- STOP: when counter==CLKS_PER_BIT-1, sample rxIN.
  - 1 -> frame complete, deliver byte, go to IDLE.
  - 0 -> frameErrorOUT pulses for 1 cycle, byte discarded, go to BREAK.
- BREAK: stay until rxIN=1, then go to IDLE. A line held low never produces repeated frames.
- Delivery latency: dataOUT/validOUT update on the clock edge after the stop-sample cycle.
- Handshake:
  - validOUT stays high and dataOUT stays stable until a cycle with validOUT=1 and readyIN=1.
  - On the following edge validOUT clears, unless a new byte loads that same edge.
- Byte completes while validOUT=1 and readyIN=0:
  - overrunOUT pulses for 1 cycle.
  - The new byte is dropped and the old byte is retained.
- Byte completes while validOUT=1 and readyIN=1 in the same cycle: the old byte is consumed, the new byte loads, validOUT stays 1, no overrun.
- busyOUT is combinationally derived from state (state != IDLE).
- Flag pulses are registered and never exceed 1 cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows data bit 7. State PARITY samples it at counter==CLKS_PER_BIT-1, then goes to STOP.
  - Parity mismatch with a good stop bit -> frameErrorOUT pulse, byte discarded, go to IDLE.
  - Bad stop bit behaves as without the macro.
- Undefined: the PARITY state and its logic are absent; frames are 8N1.

Test Plan:
- CLKS_PER_BIT=8, readyIN=1. Send 8N1 frame 0xA5 -> dataOUT=0xA5, validOUT high exactly 1 cycle, starting 1 cycle after the stop sample. No flags.
- Idle line, rxIN low for 2 cycles then high -> false start. No validOUT, no frameErrorOUT, busyOUT returns low within HALF_BIT+1 cycles.
- Send 0x3C with stop bit 0, then hold rxIN low 40 cycles, then high -> one frameErrorOUT pulse, no validOUT, busyOUT high until rxIN returns high.
- readyIN=0; send 0x11 then 0x22 -> dataOUT=0x11 retained with validOUT=1, one overrunOUT pulse. Raise readyIN -> validOUT clears next edge.
- Assert nResetIN low during data bit 4 of 0xFF, release, send 0x5A -> only 0x5A delivered, all outputs at reset values while in reset.
- UART_RX_PARITY_EN defined:
  - 0x07 with parity bit 1 -> delivered.
  - 0x07 with parity bit 0 -> frameErrorOUT pulse, no validOUT.
